// File: rtl/stream_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_arbiter_if
//  Description : Stream bundle for the N:1 stream multiplexer. Carries the
//                selection controls, the per-channel input streams and the
//                single registered output stream.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_mux_arbiter_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic                      mode;
  logic [SEL_W-1:0]          address;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_channel;
  logic                      out_valid;
  logic                      out_ready;

  // Multiplexer side: consumes the producer streams, drives the output stream
  modport slave (
    input  mode, address, in_data, in_valid, out_ready,
    output in_ready, out_data, out_channel, out_valid
  );

  // Environment side: producers, selection control and the consumer
  modport master (
    output mode, address, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_channel, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/stream_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_arbiter
//  Description : Registered N:1 valid/ready stream multiplexer. A channel is
//                chosen either by explicit address or by a round-robin
//                arbiter; the chosen word lands in a single output register
//                stage (1-cycle latency, 1 word/cycle throughput).
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_arbiter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  stream_mux_arbiter_if.slave bus
);

  // Address space covered by SEL_W; codes at or above CHANNELS never grant
  localparam int               c_SLOTS = 2 ** SEL_W;
  localparam logic [SEL_W:0]   c_CHANS = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] c_LAST  = SEL_W'(CHANNELS - 1);

  // Output stage and round-robin pointer
  logic [WIDTH-1:0] out_data_q,    out_data_d;
  logic [SEL_W-1:0] out_channel_q, out_channel_d;
  logic             out_valid_q,   out_valid_d;
  logic [SEL_W-1:0] last_q,        last_d;

  // Combinational selection signals
  logic [c_SLOTS-1:0]  w_valid_pad;
  logic                w_load_en;
  logic                w_rr_found;
  logic [SEL_W-1:0]    w_rr_idx;
  logic [SEL_W:0]      w_sum;
  logic                w_grant_vld;
  logic [SEL_W-1:0]    w_grant_idx;
  logic [WIDTH-1:0]    w_sel_data;
  logic [CHANNELS-1:0] w_ready;

  // Valid vector widened to the full address space. The unused slots read as
  // zero, so an out-of-range address simply finds nothing valid.
  generate
    if (c_SLOTS > CHANNELS) begin : g_pad
      assign w_valid_pad = {{(c_SLOTS - CHANNELS){1'b0}}, bus.in_valid};
    end else begin : g_nopad
      assign w_valid_pad = bus.in_valid;
    end
  endgenerate

  // Round-robin search from last+1 with wrap. Walking from the farthest
  // candidate to the nearest lets the nearest valid channel win.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_sum      = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      w_sum = {1'b0, last_q} + (SEL_W + 1)'(k);
      if (w_sum >= c_CHANS) begin
        w_sum = w_sum - c_CHANS;
      end
      if (w_valid_pad[w_sum[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_sum[SEL_W-1:0];
      end
    end
  end

  // Grant decision: only while the output slot is free or being drained
  always_comb begin
    w_load_en   = !out_valid_q || bus.out_ready;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    if (w_load_en) begin
      if (!bus.mode) begin
        w_grant_vld = w_valid_pad[bus.address];
        w_grant_idx = bus.address;
      end else begin
        w_grant_vld = w_rr_found;
        w_grant_idx = w_rr_idx;
      end
    end
  end

  // One-hot ready to the granted producer (forced low during reset) and the
  // data word of the granted channel
  always_comb begin
    w_ready    = '0;
    w_sel_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_ready[c] = reset_n && w_grant_vld && (w_grant_idx == SEL_W'(c));
      if (w_grant_idx == SEL_W'(c)) begin
        w_sel_data = bus.in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: load on a grant (replacing any word being drained), clear
  // valid on a drain without replacement, otherwise hold
  always_comb begin
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    last_d        = last_q;
    if (w_grant_vld) begin
      out_data_d    = w_sel_data;
      out_channel_d = w_grant_idx;
      out_valid_d   = 1'b1;
      last_d        = w_grant_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  // Output register stage and pointer; reset puts channel 0 first in line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      last_q        <= c_LAST;
    end else begin
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      last_q        <= last_d;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_valid   = out_valid_q;

endmodule
`default_nettype wire
